// File: rtl/fetch_ras.sv
// rtl/fetch_ras.sv - return address stack with speculative and commit-tracked pointers (optional macro: RAS_COMMIT_REPAIR_EN)
module fetch_ras #(
   parameter int SIZE_PC       = 32,
   parameter int RAS_DEPTH     = 16,
   parameter int RAS_DEPTH_LOG = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall_i,
   input  logic                 flagRecoverID_i,
   input  logic                 flagCallID_i,
   input  logic                 flagRtrID_i,
   input  logic [SIZE_PC-1:0]   callPCID_i,
   input  logic                 commitCall_i,
   input  logic                 commitRtr_i,
   input  logic                 recoverFlag_i,
   output logic [SIZE_PC-1:0]   addrRAS_CP_o,
   output logic                 rasEmpty_o,
   output logic                 rasFull_o
);

   localparam logic [RAS_DEPTH_LOG-1:0] PTR_ONE   = RAS_DEPTH_LOG'(1);
   localparam logic [RAS_DEPTH_LOG:0]   CNT_ONE   = (RAS_DEPTH_LOG+1)'(1);
   localparam logic [RAS_DEPTH_LOG:0]   CNT_FULL  = (RAS_DEPTH_LOG+1)'(RAS_DEPTH);

   logic [SIZE_PC-1:0]       entry [RAS_DEPTH];
   logic [RAS_DEPTH_LOG-1:0] specTos;
   logic [RAS_DEPTH_LOG:0]   specCnt;

   logic [RAS_DEPTH_LOG-1:0] specTosNext;
   logic [RAS_DEPTH_LOG:0]   specCntNext;
   logic                     wrEn;
   logic [RAS_DEPTH_LOG-1:0] wrIdx;
   logic [SIZE_PC-1:0]       wrData;

   logic push;
   logic pop;

   // Return address is the call PC plus one 8-byte instruction
   assign push   = flagRecoverID_i & flagCallID_i & ~stall_i;
   assign pop    = flagRecoverID_i & flagRtrID_i & ~stall_i;
   assign wrData = callPCID_i + SIZE_PC'(8);

`ifdef RAS_COMMIT_REPAIR_EN
   logic [RAS_DEPTH_LOG-1:0] commitTos;
   logic [RAS_DEPTH_LOG:0]   commitCnt;
   logic [RAS_DEPTH_LOG-1:0] commitTosNext;
   logic [RAS_DEPTH_LOG:0]   commitCntNext;

   // Commit pointer mirrors the speculative arithmetic but never writes entries
   always_comb begin
      commitTosNext = commitTos;
      commitCntNext = commitCnt;
      if (commitCall_i && commitRtr_i) begin
         if (commitCnt == '0) commitCntNext = CNT_ONE;
      end else if (commitCall_i) begin
         commitTosNext = commitTos + PTR_ONE;
         if (commitCnt != CNT_FULL) commitCntNext = commitCnt + CNT_ONE;
      end else if (commitRtr_i && commitCnt != '0) begin
         commitTosNext = commitTos - PTR_ONE;
         commitCntNext = commitCnt - CNT_ONE;
      end
   end

   // Commit state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         commitTos <= '0;
         commitCnt <= '0;
      end else begin
         commitTos <= commitTosNext;
         commitCnt <= commitCntNext;
      end
   end
`else
   logic unusedCommit;
   assign unusedCommit = commitCall_i ^ commitRtr_i;
`endif

   // Speculative next state; recovery wins over push/pop and suppresses the write
   always_comb begin
      specTosNext = specTos;
      specCntNext = specCnt;
      wrEn        = 1'b0;
      wrIdx       = specTos;
      if (recoverFlag_i) begin
`ifdef RAS_COMMIT_REPAIR_EN
         specTosNext = commitTosNext;
         specCntNext = commitCntNext;
`else
         specTosNext = '0;
         specCntNext = '0;
`endif
      end else if (push && pop) begin
         wrEn  = 1'b1;
         wrIdx = specTos;
         if (specCnt == '0) specCntNext = CNT_ONE;
      end else if (push) begin
         wrEn        = 1'b1;
         wrIdx       = specTos + PTR_ONE;
         specTosNext = specTos + PTR_ONE;
         if (specCnt != CNT_FULL) specCntNext = specCnt + CNT_ONE;
      end else if (pop && specCnt != '0) begin
         specTosNext = specTos - PTR_ONE;
         specCntNext = specCnt - CNT_ONE;
      end
   end

   // Speculative pointer, count and entry storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         specTos <= '0;
         specCnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) entry[i] <= '0;
      end else begin
         specTos <= specTosNext;
         specCnt <= specCntNext;
         if (wrEn) entry[wrIdx] <= wrData;
      end
   end

   assign addrRAS_CP_o = (specCnt == '0) ? '0 : entry[specTos];
   assign rasEmpty_o   = (specCnt == '0);
   assign rasFull_o    = (specCnt == CNT_FULL);

endmodule

// File: tb/tb_fetch_ras.sv
// tb/tb_fetch_ras.sv - directed self-checking bench for fetch_ras
module tb_fetch_ras;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        flagRecoverID_i;
   logic        flagCallID_i;
   logic        flagRtrID_i;
   logic [31:0] callPCID_i;
   logic        commitCall_i;
   logic        commitRtr_i;
   logic        recoverFlag_i;
   logic [31:0] addrRAS_CP_o;
   logic        rasEmpty_o;
   logic        rasFull_o;

   int total = 0;
   int bad   = 0;

   fetch_ras dut (
      .clk             (clk),
      .reset           (reset),
      .stall_i         (stall_i),
      .flagRecoverID_i (flagRecoverID_i),
      .flagCallID_i    (flagCallID_i),
      .flagRtrID_i     (flagRtrID_i),
      .callPCID_i      (callPCID_i),
      .commitCall_i    (commitCall_i),
      .commitRtr_i     (commitRtr_i),
      .recoverFlag_i   (recoverFlag_i),
      .addrRAS_CP_o    (addrRAS_CP_o),
      .rasEmpty_o      (rasEmpty_o),
      .rasFull_o       (rasFull_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clearInputs();
      stall_i = 1'b0; flagRecoverID_i = 1'b0; flagCallID_i = 1'b0; flagRtrID_i = 1'b0;
      callPCID_i = 32'h0; commitCall_i = 1'b0; commitRtr_i = 1'b0; recoverFlag_i = 1'b0;
   endtask

   // Drive one cycle of stimulus; outputs are observable on return (#1 after the edge)
   task automatic doCycle(input logic call, input logic rtr, input logic stall,
                          input logic [31:0] pc, input logic cCall, input logic cRtr,
                          input logic rec);
      flagRecoverID_i = call | rtr;
      flagCallID_i    = call;
      flagRtrID_i     = rtr;
      stall_i         = stall;
      callPCID_i      = pc;
      commitCall_i    = cCall;
      commitRtr_i     = cRtr;
      recoverFlag_i   = rec;
      @(posedge clk); #1;
      clearInputs();
   endtask

   task automatic applyReset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clearInputs();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (addrRAS_CP_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addrRAS_CP_o, 32'h0); end
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", rasEmpty_o); end
      total++; if (rasFull_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", rasFull_o); end
      reset = 1'b1;
      @(posedge clk); #1;
      total++; if (addrRAS_CP_o !== 32'h0 || rasEmpty_o !== 1'b1) begin bad++; $display("FAIL post_release got=%h/%b exp=0/1", addrRAS_CP_o, rasEmpty_o); end
   endtask

   task automatic test_call_return();
      doCycle(1, 0, 0, 32'h0040_0100, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h0040_0108) begin bad++; $display("FAIL call_addr got=%h exp=%h", addrRAS_CP_o, 32'h0040_0108); end
      total++; if (rasEmpty_o !== 1'b0) begin bad++; $display("FAIL call_empty got=%b exp=0", rasEmpty_o); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h0) begin bad++; $display("FAIL ret_addr got=%h exp=0", addrRAS_CP_o); end
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL ret_empty got=%b exp=1", rasEmpty_o); end
   endtask

   task automatic test_overflow_underflow();
      logic [31:0] exp;
      for (int k = 0; k <= 16; k++) doCycle(1, 0, 0, 32'h1000 + 32'(16 * k), 0, 0, 0);
      total++; if (rasFull_o !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", rasFull_o); end
      total++; if (addrRAS_CP_o !== 32'h1108) begin bad++; $display("FAIL full_tos got=%h exp=%h", addrRAS_CP_o, 32'h1108); end
      for (int k = 16; k >= 1; k--) begin
         exp = 32'h1008 + 32'(16 * k);
         total++; if (addrRAS_CP_o !== exp) begin bad++; $display("FAIL pop_seq k=%0d got=%h exp=%h", k, addrRAS_CP_o, exp); end
         doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      end
      total++; if (rasEmpty_o !== 1'b1 || rasFull_o !== 1'b0) begin bad++; $display("FAIL drained got=%b/%b exp=1/0", rasEmpty_o, rasFull_o); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1 || addrRAS_CP_o !== 32'h0) begin bad++; $display("FAIL underflow got=%b/%h exp=1/0", rasEmpty_o, addrRAS_CP_o); end
      doCycle(1, 0, 0, 32'h4000, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h4008) begin bad++; $display("FAIL after_underflow got=%h exp=%h", addrRAS_CP_o, 32'h4008); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL after_underflow_pop got=%b exp=1", rasEmpty_o); end
   endtask

   task automatic test_push_pop_same();
      doCycle(1, 0, 0, 32'h2000, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h2008) begin bad++; $display("FAIL pp_first got=%h exp=%h", addrRAS_CP_o, 32'h2008); end
      doCycle(1, 1, 0, 32'h3000, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h3008 || rasEmpty_o !== 1'b0) begin bad++; $display("FAIL pp_both got=%h/%b exp=%h/0", addrRAS_CP_o, rasEmpty_o, 32'h3008); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL pp_count1 got=%b exp=1", rasEmpty_o); end
      doCycle(1, 1, 0, 32'h3500, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b0 || addrRAS_CP_o !== 32'h3508) begin bad++; $display("FAIL pp_empty got=%b/%h exp=0/%h", rasEmpty_o, addrRAS_CP_o, 32'h3508); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL pp_empty_pop got=%b exp=1", rasEmpty_o); end
   endtask

   task automatic test_stall();
      doCycle(1, 0, 0, 32'h6000, 0, 0, 0);
      doCycle(1, 0, 1, 32'h7000, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h6008) begin bad++; $display("FAIL stall_call got=%h exp=%h", addrRAS_CP_o, 32'h6008); end
      doCycle(0, 1, 1, 32'h0, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h6008 || rasEmpty_o !== 1'b0) begin bad++; $display("FAIL stall_ret got=%h/%b exp=%h/0", addrRAS_CP_o, rasEmpty_o, 32'h6008); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL stall_count got=%b exp=1", rasEmpty_o); end
   endtask

   task automatic test_recover();
      applyReset();
      doCycle(1, 0, 0, 32'h0A00, 0, 0, 0);
      doCycle(1, 0, 0, 32'h0B00, 0, 0, 0);
      doCycle(1, 0, 0, 32'h0C00, 0, 0, 0);
`ifdef RAS_COMMIT_REPAIR_EN
      doCycle(0, 0, 0, 32'h0, 1, 0, 0);
      doCycle(1, 0, 0, 32'h0F00, 0, 0, 1);
      total++; if (addrRAS_CP_o !== 32'h0A08) begin bad++; $display("FAIL recover_tos got=%h exp=%h", addrRAS_CP_o, 32'h0A08); end
      doCycle(1, 0, 0, 32'h0D00, 0, 0, 0);
      doCycle(0, 0, 0, 32'h0, 1, 0, 1);
      total++; if (addrRAS_CP_o !== 32'h0D08) begin bad++; $display("FAIL recover_same_commit got=%h exp=%h", addrRAS_CP_o, 32'h0D08); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h0A08) begin bad++; $display("FAIL recover_pop got=%h exp=%h", addrRAS_CP_o, 32'h0A08); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL recover_count got=%b exp=1", rasEmpty_o); end
`else
      doCycle(0, 0, 0, 32'h0, 1, 0, 0);
      doCycle(1, 0, 0, 32'h0F00, 0, 0, 1);
      total++; if (rasEmpty_o !== 1'b1 || addrRAS_CP_o !== 32'h0) begin bad++; $display("FAIL recover_empty got=%b/%h exp=1/0", rasEmpty_o, addrRAS_CP_o); end
      doCycle(1, 0, 0, 32'h0E00, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h0E08) begin bad++; $display("FAIL recover_push got=%h exp=%h", addrRAS_CP_o, 32'h0E08); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1) begin bad++; $display("FAIL recover_count got=%b exp=1", rasEmpty_o); end
`endif
   endtask

   task automatic test_reset_midop();
      doCycle(1, 0, 0, 32'h0500, 0, 0, 0);
      doCycle(1, 0, 0, 32'h0600, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      total++; if (rasEmpty_o !== 1'b1 || addrRAS_CP_o !== 32'h0) begin bad++; $display("FAIL async_reset got=%b/%h exp=1/0", rasEmpty_o, addrRAS_CP_o); end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;
      doCycle(1, 0, 0, 32'h0800, 0, 0, 0);
      total++; if (addrRAS_CP_o !== 32'h0808) begin bad++; $display("FAIL midop_push got=%h exp=%h", addrRAS_CP_o, 32'h0808); end
      doCycle(0, 1, 0, 32'h0, 0, 0, 0);
      total++; if (rasEmpty_o !== 1'b1 || addrRAS_CP_o !== 32'h0) begin bad++; $display("FAIL midop_pop got=%b/%h exp=1/0", rasEmpty_o, addrRAS_CP_o); end
   endtask

   initial begin
      reset = 1'b0;
      clearInputs();
      test_reset();
      test_call_return();
      test_overflow_underflow();
      test_push_pop_same();
      test_stall();
      test_recover();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_ras.md
# fetch_ras

Return address stack for the fetch front end. It consumes the call/return redirect flags that FetchStage2 produces during pre-decode (`flagRecoverID`, `flagCallID`, `flagRtrID`, `callPCID`). It returns the predicted return address that FetchStage2 substitutes as the target of a BTB-missing return. The stack is a circular buffer with a speculative top-of-stack pointer and a commit-tracked pointer. On a back-end mispredict, the speculative pointer is repaired from the commit-tracked pointer.

## Interface
Parameters:
- `SIZE_PC`, 32, PC width.
- `RAS_DEPTH`, 16, number of entries; power of two.
- `RAS_DEPTH_LOG`, 4, log2(`RAS_DEPTH`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 clears all state immediately; release is synchronous to `clk`.
- `stall_i`  in  1  front-end stall; blocks speculative push and pop.
- `flagRecoverID_i`  in  1  FS2 redirect strobe, already qualified by stall and CTI-queue-full.
- `flagCallID_i`  in  1  redirect is a call.
- `flagRtrID_i`  in  1  redirect is a return.
- `callPCID_i`  in  `SIZE_PC`  PC of the call instruction.
- `commitCall_i`  in  1  a call retired this cycle.
- `commitRtr_i`  in  1  a return retired this cycle.
- `recoverFlag_i`  in  1  back-end mispredict recovery.
- `addrRAS_CP_o`  out  `SIZE_PC`  predicted return address (speculative TOS).
- `rasEmpty_o`  out  1  speculative count is 0.
- `rasFull_o`  out  1  speculative count equals `RAS_DEPTH`.

## Operation
- Storage: `RAS_DEPTH` entries of `SIZE_PC`, plus the following state:
  - `specTos` and `commitTos`, each `RAS_DEPTH_LOG` bits, pointing at the top valid entry.
  - `specCnt` and `commitCnt`, each `RAS_DEPTH_LOG+1` bits.
- Push enable: `push = flagRecoverID_i & flagCallID_i & ~stall_i`.
- Pop enable: `pop = flagRecoverID_i & flagRtrID_i & ~stall_i`.
- Push:
  - `specTos <= specTos+1` (modulo `RAS_DEPTH`).
  - `entry[specTos+1] <= callPCID_i + 8` (PISA 8-byte instructions).
  - `specCnt <= min(specCnt+1, RAS_DEPTH)`.
  - Overflow overwrites the oldest entry silently.
- Pop:
  - If `specCnt>0`: `specTos <= specTos-1` (modulo) and `specCnt <= specCnt-1`.
  - If `specCnt==0`: no state change (underflow ignored).
- Push and pop in the same cycle:
  - `entry[specTos] <= callPCID_i+8`; the pointer is unchanged.
  - `specCnt` is unchanged, except that 0 becomes 1.
- Commit tracking: `commitCall_i` and `commitRtr_i` update `commitTos`/`commitCnt` with the same arithmetic and the same saturation and underflow rules. They never write entries.
- Recovery: `recoverFlag_i` has priority over push and pop.
  - `specTos <= commitTos_next` and `specCnt <= commitCnt_next`, where `_next` includes any commit update in the same cycle.
  - Entries are not restored; entries overwritten on a wrong path stay corrupted, and this is accepted.
- `addrRAS_CP_o = (specCnt==0) ? 0 : entry[specTos]`, combinational from registers only.
- The block has no combinational path from its inputs to `addrRAS_CP_o`.

## Timing
- Reset values:
  - `addrRAS_CP_o=0`, `rasEmpty_o=1`, `rasFull_o=0`.
  - All entries, pointers and counts are 0.
- Latency: a push or pop in cycle N is visible on `addrRAS_CP_o` and the status outputs in cycle N+1.
- A return in cycle N sees the TOS as written by cycle N-1 or earlier. FS2 samples `addrRAS_CP_o` in the same cycle it asserts `flagRtrID`, then the pop takes effect.
- A recovery in cycle N makes the repaired TOS visible in cycle N+1.
- Reset asserted mid-operation clears everything asynchronously; the first push after release lands in entry 1.
- Pointer wrap: `RAS_DEPTH-1` incremented gives 0; 0 decremented gives `RAS_DEPTH-1`.

## Configuration
- `RAS_COMMIT_REPAIR_EN` defined:
  - Commit pointer and count are implemented; recovery behaves as described under Operation.
- `RAS_COMMIT_REPAIR_EN` undefined:
  - No commit state is implemented; `commitCall_i` and `commitRtr_i` are ignored.
  - `recoverFlag_i` sets `specTos=0` and `specCnt=0`, which empties the stack; entries are untouched.

## Test plan
- Reset held low, then released → `addrRAS_CP_o=0`, `rasEmpty_o=1`, `rasFull_o=0`.
- Call with `callPCID_i=0x00400100` → next cycle `addrRAS_CP_o=0x00400108`, `rasEmpty_o=0`. Then a return → next cycle `addrRAS_CP_o=0`, `rasEmpty_o=1`.
- 17 calls with `callPCID_i=0x1000+16k` (k=0..16) → `rasFull_o=1`, TOS=`0x1108`.
  - The following 16 returns yield `0x1108` down to `0x1018`.
  - A 17th return leaves `rasEmpty_o=1` with no pointer change.
- Push `0x2000` (TOS `0x2008`), then one cycle with both push (`callPCID_i=0x3000`) and pop → TOS=`0x3008`, count still 1.
- With `RAS_COMMIT_REPAIR_EN`: push `0xA00`, `0xB00`, `0xC00`; `commitCall_i` once; then `recoverFlag_i` → next cycle count=1, `addrRAS_CP_o=0xA08`.
- Call asserted with `stall_i=1` → no change to TOS or count.
